// File: rtl/fod_cali_seq.sv
// Power-up / calibration sequencer for the FOD digital controller.
// Define FOD_SEQ_OFSTCALI_EN to add the offset-calibration stage between DTCCALI and RUN.
module fod_cali_seq #(
  parameter int WFCW      = 22,
  parameter int CNTW      = 16,
  parameter int T_RST     = 16,
  parameter int T_PCALI   = 4096,
  parameter int T_DTCCALI = 8192,
  parameter int T_OFST    = 4096
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  input  logic            ABORT,
  input  logic            HOP_REQ,
  input  logic [WFCW-1:0] FCW_IN,
  output logic            NARST,
  output logic [WFCW-1:0] FCW_FOD,
  output logic            PCALI_EN,
  output logic            DTCCALI_EN,
  output logic            OFSTCALI_EN,
  output logic            SYS_EN,
  output logic            FREQ_HOP,
  output logic            HOP_ACK,
  output logic            BUSY,
  output logic            LOCKED,
  output logic [2:0]      STATE
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RSTHOLD  = 3'd1,
    PCALI    = 3'd2,
    DTCCALI  = 3'd3,
    OFSTCALI = 3'd4,
    RUN      = 3'd5,
    HOP      = 3'd6
  } state_t;

  localparam logic [CNTW-1:0] LIM_RST   = CNTW'(T_RST - 1);
  localparam logic [CNTW-1:0] LIM_PCALI = CNTW'(T_PCALI - 1);
  localparam logic [CNTW-1:0] LIM_DTC   = CNTW'(T_DTCCALI - 1);
  localparam logic [CNTW-1:0] LIM_OFST  = CNTW'(T_OFST - 1);

`ifdef FOD_SEQ_OFSTCALI_EN
  localparam state_t AFTER_DTC = OFSTCALI;
  localparam bit     HAS_OFST  = 1'b1;
`else
  localparam state_t AFTER_DTC = RUN;
  localparam bit     HAS_OFST  = 1'b0;
`endif

  state_t            state, state_n;
  logic [CNTW-1:0]   cnt;
  logic [WFCW-1:0]   fcw_n;
  logic              hop_n;
  logic              narst_n, pcali_n, dtc_n, ofst_n, sys_n, busy_n, locked_n;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      cnt         <= '0;
      FCW_FOD     <= '0;
      NARST       <= 1'b0;
      PCALI_EN    <= 1'b0;
      DTCCALI_EN  <= 1'b0;
      OFSTCALI_EN <= 1'b0;
      SYS_EN      <= 1'b0;
      FREQ_HOP    <= 1'b0;
      HOP_ACK     <= 1'b0;
      BUSY        <= 1'b0;
      LOCKED      <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= (state_n != state) ? '0 : cnt + 1'b1;
      FCW_FOD     <= fcw_n;
      NARST       <= narst_n;
      PCALI_EN    <= pcali_n;
      DTCCALI_EN  <= dtc_n;
      OFSTCALI_EN <= ofst_n;
      SYS_EN      <= sys_n;
      FREQ_HOP    <= hop_n;
      HOP_ACK     <= hop_n;
      BUSY        <= busy_n;
      LOCKED      <= locked_n;
    end
  end

  assign STATE = state;

  // Next state, then the registered outputs decoded from the state being entered.
  always_comb begin
    state_n = state;
    fcw_n   = FCW_FOD;
    hop_n   = 1'b0;
    if (state != IDLE && ABORT) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: if (START) begin
          state_n = RSTHOLD;
          fcw_n   = FCW_IN;
        end
        RSTHOLD:  if (cnt == LIM_RST)   state_n = PCALI;
        PCALI:    if (cnt == LIM_PCALI) state_n = DTCCALI;
        DTCCALI:  if (cnt == LIM_DTC)   state_n = AFTER_DTC;
        OFSTCALI: if (cnt == LIM_OFST)  state_n = RUN;
        RUN: if (HOP_REQ) begin
          state_n = HOP;
          fcw_n   = FCW_IN;
          hop_n   = 1'b1;
        end
        HOP:      if (cnt == LIM_PCALI) state_n = RUN;
        default:  state_n = IDLE;
      endcase
    end

    narst_n  = (state_n != IDLE) && (state_n != RSTHOLD);
    pcali_n  = narst_n;
    dtc_n    = (state_n == DTCCALI) || (state_n == OFSTCALI) ||
               (state_n == RUN) || (state_n == HOP);
    ofst_n   = HAS_OFST && ((state_n == OFSTCALI) || (state_n == RUN) || (state_n == HOP));
    sys_n    = (state_n == RUN) || (state_n == HOP);
    busy_n   = (state_n != IDLE);
    locked_n = (state_n == RUN);
  end

endmodule

// File: tb/tb_fod_cali_seq.sv
// Directed, table-driven bench for fod_cali_seq (short dwell times).
module tb_fod_cali_seq;
  localparam int WFCW = 22;
`ifdef FOD_SEQ_OFSTCALI_EN
  localparam int       RUN_AT = 37;
  localparam bit [8:0] RUNF   = 9'b111110011;
  localparam bit [8:0] HOP1F  = 9'b111111110;
  localparam bit [8:0] HOPF   = 9'b111110010;
`else
  localparam int       RUN_AT = 29;
  localparam bit [8:0] RUNF   = 9'b111010011;
  localparam bit [8:0] HOP1F  = 9'b111011110;
  localparam bit [8:0] HOPF   = 9'b111010010;
`endif

  logic            CLK = 1'b0, RST = 1'b1, START = 1'b0, ABORT = 1'b0, HOP_REQ = 1'b0;
  logic [WFCW-1:0] FCW_IN = '0;
  logic            NARST, PCALI_EN, DTCCALI_EN, OFSTCALI_EN, SYS_EN;
  logic            FREQ_HOP, HOP_ACK, BUSY, LOCKED;
  logic [WFCW-1:0] FCW_FOD;
  logic [2:0]      STATE;

  always #5 CLK = ~CLK;

  fod_cali_seq #(.WFCW(WFCW), .CNTW(16), .T_RST(4), .T_PCALI(8), .T_DTCCALI(16), .T_OFST(8)) dut (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .HOP_REQ(HOP_REQ), .FCW_IN(FCW_IN),
    .NARST(NARST), .FCW_FOD(FCW_FOD), .PCALI_EN(PCALI_EN), .DTCCALI_EN(DTCCALI_EN),
    .OFSTCALI_EN(OFSTCALI_EN), .SYS_EN(SYS_EN), .FREQ_HOP(FREQ_HOP), .HOP_ACK(HOP_ACK),
    .BUSY(BUSY), .LOCKED(LOCKED), .STATE(STATE)
  );

  // flags order: NARST PCALI DTCCALI OFSTCALI SYS_EN FREQ_HOP HOP_ACK BUSY LOCKED
  typedef struct {
    int        e;
    bit [2:0]  st;
    bit [8:0]  fl;
    bit [21:0] fcw;
  } vec_t;

  vec_t tbl[$];
  int   nchk = 0;
  int   nerr = 0;

  function automatic logic [33:0] obs();
    return {STATE, NARST, PCALI_EN, DTCCALI_EN, OFSTCALI_EN, SYS_EN, FREQ_HOP, HOP_ACK,
            BUSY, LOCKED, FCW_FOD};
  endfunction

  task automatic chk(input string name, input bit [2:0] st, input bit [8:0] fl, input bit [21:0] fcw);
    logic [33:0] got;
    logic [33:0] exp;
    got = obs();
    exp = {st, fl, fcw};
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got st=%0d flags=%b fcw=%h, expected st=%0d flags=%b fcw=%h",
               name, got[33:31], got[30:22], got[21:0], st, fl, fcw);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic bringup(input bit inject, input int abort_at, input bit with_abort);
    FCW_IN = 22'h4C000;
    START  = 1'b1;
    ABORT  = with_abort;
    for (int e = 1; e <= RUN_AT; e++) begin
      tick();
      START = 1'b0;
      ABORT = 1'b0;
      if (abort_at > 0 && e == abort_at + 1) begin
        chk("abort_dtccali", 3'd0, 9'b0, 22'h4C000);
        return;
      end
      foreach (tbl[i])
        if (tbl[i].e == e) chk($sformatf("bringup_e%0d", e), tbl[i].st, tbl[i].fl, tbl[i].fcw);
      if (inject) begin
        case (e)
          6: begin START = 1'b1; FCW_IN = 22'h12345; end
          7: begin START = 1'b0; HOP_REQ = 1'b1; end
          8: begin HOP_REQ = 1'b0; FCW_IN = 22'h4C000; end
          default: ;
        endcase
      end
      if (abort_at > 0 && e == abort_at) ABORT = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl.push_back('{1,  3'd1, 9'b000000010, 22'h4C000});
    tbl.push_back('{4,  3'd1, 9'b000000010, 22'h4C000});
    tbl.push_back('{5,  3'd2, 9'b110000010, 22'h4C000});
    tbl.push_back('{8,  3'd2, 9'b110000010, 22'h4C000});
    tbl.push_back('{9,  3'd2, 9'b110000010, 22'h4C000});
    tbl.push_back('{12, 3'd2, 9'b110000010, 22'h4C000});
    tbl.push_back('{13, 3'd3, 9'b111000010, 22'h4C000});
    tbl.push_back('{28, 3'd3, 9'b111000010, 22'h4C000});
`ifdef FOD_SEQ_OFSTCALI_EN
    tbl.push_back('{29, 3'd4, 9'b111100010, 22'h4C000});
    tbl.push_back('{36, 3'd4, 9'b111100010, 22'h4C000});
    tbl.push_back('{37, 3'd5, RUNF,         22'h4C000});
`else
    tbl.push_back('{29, 3'd5, RUNF,         22'h4C000});
`endif

    tick();
    tick();
    chk("reset", 3'd0, 9'b0, 22'h0);
    RST = 1'b0;

    bringup(1'b1, 0, 1'b0);

    tick();
    chk("run_hold", 3'd5, RUNF, 22'h4C000);
    HOP_REQ = 1'b1;
    FCW_IN  = 22'h50000;
    tick();
    HOP_REQ = 1'b0;
    chk("hop_strobe", 3'd6, HOP1F, 22'h50000);
    for (int k = 2; k <= 8; k++) begin
      tick();
      chk($sformatf("hop_c%0d", k), 3'd6, HOPF, 22'h50000);
    end
    tick();
    chk("hop_relock", 3'd5, RUNF, 22'h50000);

    // Held request: a fresh hop on every RUN re-entry.
    HOP_REQ = 1'b1;
    FCW_IN  = 22'h60000;
    tick();
    chk("held_hop1", 3'd6, HOP1F, 22'h60000);
    tick();
    chk("held_hop1_c2", 3'd6, HOPF, 22'h60000);
    for (int k = 3; k <= 8; k++) tick();
    tick();
    chk("held_reenter_run", 3'd5, RUNF, 22'h60000);
    tick();
    HOP_REQ = 1'b0;
    chk("held_hop2", 3'd6, HOP1F, 22'h60000);
    for (int k = 2; k <= 8; k++) tick();
    tick();
    chk("held_relock", 3'd5, RUNF, 22'h60000);

    ABORT  = 1'b1;
    FCW_IN = 22'h7FFFF;
    tick();
    ABORT = 1'b0;
    chk("abort_run", 3'd0, 9'b0, 22'h60000);

    bringup(1'b0, 20, 1'b0);

    bringup(1'b0, 0, 1'b1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("reset_midrun", 3'd0, 9'b0, 22'h0);

    bringup(1'b0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/fod_cali_seq.md
Name: fod_cali_seq

Overview:
- Power-up and calibration sequencer for the fractional output divider (FOD) digital controller.
- Drives the FOD control fields (NARST, FCW_FOD, PCALI_EN, DTCCALI_EN, OFSTCALI_EN, SYS_EN, FREQ_HOP) from a single START pulse, in place of fixed-delay software writes.
- Handles runtime frequency-hop requests by reloading FCW, pulsing FREQ_HOP and re-settling phase calibration before re-asserting LOCKED.

Parameters:
WFCW, 22, FCW width (integer bits + fractional bits, 6+16).
CNTW, 16, width of the dwell counter.
T_RST, 16, cycles NARST is held low after START; must be >= 1.
T_PCALI, 4096, phase-cal settle cycles, used at bring-up and after each hop; must be >= 1.
T_DTCCALI, 8192, DTC-gain calibration dwell cycles; must be >= 1.
T_OFST, 4096, offset calibration dwell cycles; used only with the macro; must be >= 1.

Ports:
CLK  in  1  system clock; all logic is on the rising edge.
RST  in  1  synchronous, active-high reset.
START  in  1  one-cycle request to begin bring-up; sampled only in IDLE.
ABORT  in  1  return to IDLE from any state.
HOP_REQ  in  1  frequency-hop request; sampled only in RUN.
FCW_IN  in  WFCW  new frequency control word, captured on START or HOP_REQ.
NARST  out  1  FOD active-low reset.
FCW_FOD  out  WFCW  registered FCW driven to the FOD.
PCALI_EN  out  1  phase calibration enable.
DTCCALI_EN  out  1  DTC gain calibration enable.
OFSTCALI_EN  out  1  offset calibration enable.
SYS_EN  out  1  FOD system output enable.
FREQ_HOP  out  1  one-cycle hop strobe to the FOD.
HOP_ACK  out  1  one-cycle acknowledge of an accepted HOP_REQ.
BUSY  out  1  high in every state except IDLE.
LOCKED  out  1  high only in RUN.
STATE  out  3  state code: IDLE=0, RSTHOLD=1, PCALI=2, DTCCALI=3, OFSTCALI=4, RUN=5, HOP=6.

Behaviour:
- All outputs are registered and take their state value in the first cycle a state is entered.
- RST=1 at a clock edge sets every output to 0, including NARST=0 and FCW_FOD=0; STATE=IDLE; counter=0. This applies mid-operation as well.
- Dwell counter: cleared on every state entry and incremented each cycle. A timed state exits when count==T_x-1, so each timed state lasts exactly T_x cycles.
- IDLE:
  - Outputs: NARST=0, all enables 0, FCW_FOD holds its value.
  - START=1: FCW_FOD<=FCW_IN, next state RSTHOLD.
- RSTHOLD: NARST=0 for T_RST cycles, then PCALI.
- PCALI: NARST=1, PCALI_EN=1 for T_PCALI cycles, then DTCCALI.
- DTCCALI: PCALI_EN=1, DTCCALI_EN=1 for T_DTCCALI cycles, then OFSTCALI (macro defined) or RUN (macro undefined).
- OFSTCALI: PCALI_EN, DTCCALI_EN and OFSTCALI_EN all 1 for T_OFST cycles, then RUN.
- RUN:
  - Outputs: SYS_EN=1, LOCKED=1; all enables entered so far stay 1 for background tracking.
  - HOP_REQ=1: FCW_FOD<=FCW_IN, next state HOP.
- HOP:
  - First cycle: FREQ_HOP=1 and HOP_ACK=1; both are 0 from the second cycle on.
  - LOCKED=0 and SYS_EN=1; the calibration enables are unchanged.
  - Lasts T_PCALI cycles, then RUN.
- ABORT=1 in any non-IDLE state: next state IDLE with IDLE outputs; FCW_FOD is retained.
- Priority: RST > ABORT > START/HOP_REQ > timer exit.
- START outside IDLE is ignored. HOP_REQ outside RUN is ignored and gets no HOP_ACK.
- HOP_REQ held high in RUN: one hop per entry into RUN; a level still high on RUN re-entry starts another hop.
- START and ABORT both high in IDLE: START is accepted.
- Counter saturation never occurs when every T_x <= 2^CNTW.

Optional Feature:
- Macro: FOD_SEQ_OFSTCALI_EN.
- Defined: the OFSTCALI state exists. OFSTCALI_EN rises on entry to OFSTCALI and stays high through RUN and HOP.
- Undefined: DTCCALI goes directly to RUN, OFSTCALI_EN is tied to 0, and STATE code 4 is never produced.

Test Plan:
- Common setup: T_RST=4, T_PCALI=8, T_DTCCALI=16, T_OFST=8; cycle n is the nth rising edge after START is sampled at edge 0.
- Reset: hold RST for 2 cycles -> all outputs 0, STATE=0, BUSY=0.
- Bring-up with FCW_IN=0x4C000 (4.75) and START:
  - edge1: FCW_FOD=0x4C000, STATE=1, NARST=0.
  - edge5: NARST=1, PCALI_EN=1.
  - edge13: DTCCALI_EN=1.
  - Macro defined: edge29 OFSTCALI_EN=1, edge37 LOCKED=1, SYS_EN=1.
  - Macro undefined: edge29 LOCKED=1.
- Hop: in RUN, HOP_REQ for 1 cycle with FCW_IN=0x50000 -> next edge FCW_FOD=0x50000, FREQ_HOP=1 and HOP_ACK=1 for exactly 1 cycle, LOCKED=0 for 8 cycles, then LOCKED=1.
- Abort: ABORT at edge 20 (in DTCCALI) -> edge21 STATE=0, NARST=0, all enables 0, FCW_FOD=0x4C000.
- Ignored requests: START at edge 6 and HOP_REQ at edge 7 -> sequence timing unchanged, no HOP_ACK, FCW_FOD unchanged.
- Reset mid-run: RST asserted in RUN -> next edge all outputs 0, FCW_FOD=0, STATE=0; a subsequent START repeats the bring-up scenario timing exactly.
